// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: entry layout, flag bit
// positions inside the entry flags nibble, and the control FSM states.
package trace_pkg;

    // Widest DATA_W the entry struct can carry. Narrower instances zero-extend
    // into the struct; the constant-zero upper bits trim away in synthesis.
    localparam int MAX_DATA_W = 64;

    localparam int FLAG_REG_WE = 0;
    localparam int FLAG_MEM_RD = 1;
    localparam int FLAG_MEM_WR = 2;
    localparam int FLAG_HALT   = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_WDOG   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]            flags;
        logic [3:0]            reg_idx;
        logic [MAX_DATA_W-1:0] reg_data;
        logic [MAX_DATA_W-1:0] mem_addr;
        logic [MAX_DATA_W-1:0] mem_data;
    } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace store with a registered occupancy count. The head entry is
// shown whenever the store is non-empty; read data reads zero while empty so
// stale storage never leaks after reset.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          rd_ready,
    output logic          rd_valid,
    output entry_t        rdata,
    output logic [AW:0]   level,
    output logic          overflow
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop_oldest;

    assign rd_valid    = (count != '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign pop         = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full store still accepts.
    assign wr_en       = push & (!full | pop | (OVERWRITE != 0));
    assign drop_oldest = push & full & !pop & (OVERWRITE != 0);
    assign rdata       = rd_valid ? mem[rd_ptr] : '0;
    assign level       = count;

    // Entry storage; no reset needed since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop | drop_oldest) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en & !pop & !drop_oldest) begin
                count <= count + (AW+1)'(1);
            end else if (pop & !wr_en) begin
                count <= count - (AW+1)'(1);
            end
            if (push & full & !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture: builds one entry per retiring event, keeps cycle and
// instruction counters, and stops capture on halt or watchdog expiry.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | capturing; cycle counter advancing
//   ST_HALTED | halt observed; capture and counters frozen until reset
//   ST_WDOG   | cycle limit reached without halt; frozen until reset
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int CYC_LIMIT = 100000,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en,
    input  logic                     reg_we,
    input  logic [3:0]               reg_idx,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     mem_rd,
    input  logic                     mem_wr,
    input  logic [DATA_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic                     halt,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [3:0]               rd_flags,
    output logic [3:0]               rd_reg_idx,
    output logic [DATA_W-1:0]        rd_reg_data,
    output logic [DATA_W-1:0]        rd_mem_addr,
    output logic [DATA_W-1:0]        rd_mem_data,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         inst_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     halted,
    output logic                     wdog_err
);

    state_t            state;
    state_t            state_next;
    logic              running;
    logic              at_limit;
    logic              push;
    entry_t            entry;
    entry_t            rd_entry;
    logic              unused_rd_hi;

    assign at_limit = (cycle_count == CNT_W'(CYC_LIMIT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs; halt wins over a coincident limit.
    always_comb begin
        state_next = state;
        running    = 1'b0;
        halted     = 1'b0;
        wdog_err   = 1'b0;
        unique case (state)
            ST_RUN: begin
                running = 1'b1;
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (at_limit) begin
                    state_next = ST_WDOG;
                end
            end
            ST_HALTED: halted   = 1'b1;
            ST_WDOG:   wdog_err = 1'b1;
            default:   state_next = ST_RUN;
        endcase
    end

    // Cycle count stops on the transition edge so it reads the last RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
            inst_count  <= '0;
        end else if (running) begin
            if (state_next == ST_RUN) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (halt | reg_we | mem_wr) begin
                inst_count <= inst_count + CNT_W'(1);
            end
        end
    end

    assign push = running & trace_en & (reg_we | mem_rd | mem_wr | halt);

    // Assemble the entry for this cycle; store wins over load for mem_data.
    always_comb begin
        entry = '0;
        entry.flags[FLAG_REG_WE] = reg_we;
        entry.flags[FLAG_MEM_RD] = mem_rd;
        entry.flags[FLAG_MEM_WR] = mem_wr;
        entry.flags[FLAG_HALT]   = halt;
        if (reg_we) begin
            entry.reg_idx  = reg_idx;
            entry.reg_data = MAX_DATA_W'(reg_data);
        end
        if (mem_rd | mem_wr) begin
            entry.mem_addr = MAX_DATA_W'(mem_addr);
        end
        if (mem_wr) begin
            entry.mem_data = MAX_DATA_W'(mem_wdata);
        end else if (mem_rd) begin
            entry.mem_data = MAX_DATA_W'(mem_rdata);
        end
    end

    trace_fifo #(
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    (entry),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rdata    (rd_entry),
        .level    (level),
        .overflow (overflow)
    );

    assign rd_flags     = rd_entry.flags;
    assign rd_reg_idx   = rd_entry.reg_idx;
    assign rd_reg_data  = rd_entry.reg_data[DATA_W-1:0];
    assign rd_mem_addr  = rd_entry.mem_addr[DATA_W-1:0];
    assign rd_mem_data  = rd_entry.mem_data[DATA_W-1:0];
    // Upper struct bits above DATA_W are always zero.
    assign unused_rd_hi = ^{rd_entry.reg_data, rd_entry.mem_addr, rd_entry.mem_data};

endmodule
